// File: rtl/dpad_ramp_pkg.sv
// Shared mode encoding and saturating arithmetic for the d-pad analog ramp emulator.
// Arithmetic helpers run at SAT_W bits so any WIDTH below that saturates without wrapping.
package dpad_ramp_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_PASS   = 2'b00;
   localparam mode_t MODE_HOLD   = 2'b01;
   localparam mode_t MODE_SPRING = 2'b10;

   localparam int unsigned SAT_W = 32;

   // Add or subtract a step, clamping the result to [lo, hi]; the extra MSB catches carry/borrow.
   function automatic logic [SAT_W-1:0] sat_step(input logic [SAT_W-1:0] val,
                                                 input logic [SAT_W-1:0] step,
                                                 input logic             sub,
                                                 input logic [SAT_W-1:0] lo,
                                                 input logic [SAT_W-1:0] hi);
      logic [SAT_W:0] r;
      if (sub) begin
         r = {1'b0, val} - {1'b0, step};
         if (r[SAT_W] || (r[SAT_W-1:0] < lo)) return lo;
      end else begin
         r = {1'b0, val} + {1'b0, step};
         if (r[SAT_W] || (r[SAT_W-1:0] > hi)) return hi;
      end
      return r[SAT_W-1:0];
   endfunction

   function automatic logic [SAT_W-1:0] sat_clamp(input logic [SAT_W-1:0] v,
                                                  input logic [SAT_W-1:0] lo,
                                                  input logic [SAT_W-1:0] hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/dpad_ramp_channel.sv
// One control channel: stick conversion, button ramp register, hold-acceleration counter
// and end-stop flags.
module dpad_ramp_channel
   import dpad_ramp_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned MIN_VAL     = 0,
   parameter int unsigned MAX_VAL     = 254,
   parameter int unsigned REST_VAL    = 0,
   parameter int unsigned STEP        = 1,
   parameter int unsigned ACCEL_TICKS = 64,
   parameter int unsigned ACCEL_STEP  = 4
) (
   input  logic             clk_sys,
   input  logic             RESET_L,
   input  logic             tick,
   input  logic             inc,
   input  logic             dec,
   input  logic             invert,
   input  logic             clear,
   input  logic [WIDTH-1:0] analog_in,
   input  mode_t            mode,
   output logic [WIDTH-1:0] value_out,
   output logic             at_min,
   output logic             at_max
);

   localparam int unsigned HW = (ACCEL_TICKS > 0) ? $clog2(ACCEL_TICKS + 1) : 1;
   localparam logic [HW-1:0] HMAX = HW'(ACCEL_TICKS);

   localparam logic [SAT_W-1:0] HALF    = SAT_W'(1) << (WIDTH - 1);
   localparam logic [SAT_W-1:0] MIN_W   = SAT_W'(MIN_VAL);
   localparam logic [SAT_W-1:0] MAX_W   = SAT_W'(MAX_VAL);
   localparam logic [SAT_W-1:0] REST_W  = SAT_W'(REST_VAL);
   localparam logic [SAT_W-1:0] STEP_W  = SAT_W'(STEP);
   localparam logic [SAT_W-1:0] ACCEL_W = SAT_W'(ACCEL_STEP);

   localparam logic [WIDTH-1:0] MIN_N  = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_N  = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] REST_N = WIDTH'(REST_VAL);

   logic [WIDTH-1:0] val_q, val_d;
   logic [HW-1:0]    hcnt_q, hcnt_d;
   logic             dir_q, dir_d;

   logic [SAT_W-1:0] s_ext, u_raw, val_w, step_w;
   logic             single, same_run, accel;

   // Signed stick to offset-binary; result is always non-negative so wide modular math is exact.
   assign s_ext = SAT_W'($signed(analog_in));
   assign u_raw = invert ? (HALF - SAT_W'(1) - s_ext) : (s_ext + HALF);

   assign val_w    = SAT_W'(val_q);
   assign single   = inc ^ dec;
   assign same_run = (hcnt_q != '0) && (dir_q == inc);
   assign accel    = (ACCEL_TICKS != 0) && single && same_run && (hcnt_q == HMAX);
   assign step_w   = accel ? ACCEL_W : STEP_W;

   always_comb begin
      val_d  = val_q;
      hcnt_d = hcnt_q;
      dir_d  = dir_q;
      if (clear) begin
         val_d  = REST_N;
         hcnt_d = '0;
      end else if (mode == MODE_PASS) begin
         val_d  = WIDTH'(sat_clamp(u_raw, MIN_W, MAX_W));
         hcnt_d = '0;
      end else if (tick) begin
         if (single) begin
            val_d = WIDTH'(sat_step(val_w, step_w, dec, MIN_W, MAX_W));
            dir_d = inc;
            // A new direction restarts the run, counting this tick as its first.
            if (ACCEL_TICKS == 0)   hcnt_d = '0;
            else if (!same_run)     hcnt_d = HW'(1);
            else if (hcnt_q != HMAX) hcnt_d = hcnt_q + HW'(1);
         end else begin
            hcnt_d = '0;
            if ((mode == MODE_SPRING) && !inc && !dec) begin
               val_d = WIDTH'(sat_step(val_w, STEP_W, val_w > REST_W, REST_W, REST_W));
            end
         end
      end
   end

   always_ff @(posedge clk_sys or negedge RESET_L) begin
      if (!RESET_L) begin
         val_q  <= REST_N;
         hcnt_q <= '0;
         dir_q  <= 1'b0;
      end else begin
         val_q  <= val_d;
         hcnt_q <= hcnt_d;
         dir_q  <= dir_d;
      end
   end

   assign value_out = val_q;
   assign at_min    = (val_q == MIN_N);
   assign at_max    = (val_q == MAX_N);

endmodule

// File: rtl/dpad_analog_ramp.sv
// Multi-channel d-pad/stick to analog control emulator: shared ramp prescaler plus one
// dpad_ramp_channel per channel.
module dpad_analog_ramp
   import dpad_ramp_pkg::*;
#(
   parameter int unsigned CHANNELS    = 2,
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned TICK_DIV    = 196850,
   parameter int unsigned MIN_VAL     = 0,
   parameter int unsigned MAX_VAL     = 254,
   parameter int unsigned REST_VAL    = 0,
   parameter int unsigned STEP        = 1,
   parameter int unsigned ACCEL_TICKS = 64,
   parameter int unsigned ACCEL_STEP  = 4
) (
   input  logic                      clk_sys,
   input  logic                      RESET_L,
   input  logic [CHANNELS-1:0]       inc,
   input  logic [CHANNELS-1:0]       dec,
   input  logic [CHANNELS*WIDTH-1:0] analog_in,
   input  logic [CHANNELS-1:0]       invert,
   input  logic [2*CHANNELS-1:0]     mode,
   input  logic                      clear,
   output logic [CHANNELS*WIDTH-1:0] value_out,
   output logic [CHANNELS-1:0]       at_min,
   output logic [CHANNELS-1:0]       at_max,
   output logic                      tick_out
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic          tick, tick_q;

   // With TICK_DIV == 1 the counter sits at zero and every cycle is a tick.
   assign tick = (cnt_q == LAST);

   always_ff @(posedge clk_sys or negedge RESET_L) begin
      if (!RESET_L) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= tick ? '0 : cnt_q + CW'(1);
         tick_q <= tick;
      end
   end

   assign tick_out = tick_q;

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      dpad_ramp_channel #(
         .WIDTH       (WIDTH),
         .MIN_VAL     (MIN_VAL),
         .MAX_VAL     (MAX_VAL),
         .REST_VAL    (REST_VAL),
         .STEP        (STEP),
         .ACCEL_TICKS (ACCEL_TICKS),
         .ACCEL_STEP  (ACCEL_STEP)
      ) u_ch (
         .clk_sys   (clk_sys),
         .RESET_L   (RESET_L),
         .tick      (tick),
         .inc       (inc[n]),
         .dec       (dec[n]),
         .invert    (invert[n]),
         .clear     (clear),
         .analog_in (analog_in[n*WIDTH +: WIDTH]),
         .mode      (mode[2*n +: 2]),
         .value_out (value_out[n*WIDTH +: WIDTH]),
         .at_min    (at_min[n]),
         .at_max    (at_max[n])
      );
   end

endmodule
